// File: rtl/tl_mem_sched_if.sv
// tl_mem_sched_if: A/D channel and memory-port signals between a tile, the scheduler and the memory model.
// The slave modport is the scheduler's view; master is the environment driving it.
interface tl_mem_sched_if;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_opcode;
   logic [2:0]  a_size;
   logic [2:0]  a_source;
   logic [31:0] a_address;
   logic [7:0]  a_mask;
   logic [63:0] a_data;
   logic        d_valid;
   logic        d_ready;
   logic [2:0]  d_opcode;
   logic [1:0]  d_param;
   logic [2:0]  d_size;
   logic [2:0]  d_source;
   logic [1:0]  d_sink;
   logic        d_denied;
   logic [63:0] d_data;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_write;
   logic [31:0] mem_req_addr;
   logic [7:0]  mem_req_mask;
   logic [63:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [63:0] mem_rdata;
   modport slave (
      input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
      input  d_ready, mem_req_ready, mem_resp_valid, mem_rdata,
      output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_mask, mem_req_wdata
   );
   modport master (
      output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
      output d_ready, mem_req_ready, mem_resp_valid, mem_rdata,
      input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_mask, mem_req_wdata
   );
endinterface

// File: rtl/tl_mem_sched.sv
// tl_mem_sched: TileLink-UL A/D scheduler with core reset sequencer, in-order FIFO and one outstanding memory access.
// Define TL_SCHED_ERR_EN to deny requests outside [MEM_BASE, MEM_BASE+MEM_SIZE).
module tl_mem_sched #(
   parameter int DEPTH        = 4,
   parameter int RESET_CYCLES = 2
`ifdef TL_SCHED_ERR_EN
   ,
   parameter logic [31:0] MEM_BASE = 32'h8000_0000,
   parameter logic [31:0] MEM_SIZE = 32'h0001_0000
`endif
) (
   input  logic           clock,
   input  logic           reset_n,
   output logic           core_reset,
   tl_mem_sched_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = ($clog2(RESET_CYCLES) < 2) ? 2 : $clog2(RESET_CYCLES);
   typedef struct packed {
      logic [2:0]  opcode;
      logic [2:0]  size;
      logic [2:0]  source;
      logic [31:0] addr;
      logic [7:0]  mask;
      logic [63:0] data;
      logic        deny;
   } entry_t;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
   state_t        state, state_nx;
   entry_t        fifo [DEPTH];
   entry_t        ne, cur;
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic [RW-1:0] rst_cnt;
   logic [63:0]   rdata;
   logic          full, empty, push, pop, deny, is_get;
   state_t        head_st;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         rst_cnt    <= '0;
         core_reset <= 1'b1;
      end else if (core_reset) begin
         rst_cnt    <= rst_cnt + 1'b1;
         core_reset <= rst_cnt != RW'(RESET_CYCLES - 1);
      end
   assign full        = cnt == (AW+1)'(DEPTH);
   assign empty       = cnt == '0;
   assign bus.a_ready = !core_reset && !full;
   assign push        = bus.a_valid && bus.a_ready;
   assign pop         = !empty && (state == IDLE || (state == RESP && bus.d_ready));
`ifdef TL_SCHED_ERR_EN
   assign deny = !(bus.a_opcode inside {3'd0, 3'd1, 3'd4}) || bus.a_size > 3'd3 ||
                 {1'b0, bus.a_address} < {1'b0, MEM_BASE} ||
                 {1'b0, bus.a_address} >= {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
`else
   assign deny = !(bus.a_opcode inside {3'd0, 3'd1, 3'd4}) || bus.a_size > 3'd3;
`endif
   assign ne = {bus.a_opcode, bus.a_size, bus.a_source, bus.a_address, bus.a_mask, bus.a_data, deny};
   always_ff @(posedge clock)
      if (push) fifo[wp] <= ne;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         state <= IDLE;
         cur   <= '0;
         rdata <= '0;
      end else begin
         wp    <= wp + AW'(push);
         rp    <= rp + AW'(pop);
         cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         state <= state_nx;
         if (pop) cur <= fifo[rp];
         if (state == WAIT && bus.mem_resp_valid && cur.opcode == 3'd4) rdata <= bus.mem_rdata;
      end
   // Denied entries skip memory and go straight to the response.
   assign head_st = fifo[rp].deny ? RESP : REQ;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = empty ? IDLE : head_st;
         REQ:     state_nx = bus.mem_req_ready ? WAIT : REQ;
         WAIT:    state_nx = bus.mem_resp_valid ? RESP : WAIT;
         default: state_nx = !bus.d_ready ? RESP : (empty ? IDLE : head_st);
      endcase
   end
   assign is_get            = cur.opcode == 3'd4 && !cur.deny;
   assign bus.mem_req_valid = state == REQ;
   assign bus.mem_req_write = state == REQ && cur.opcode != 3'd4;
   assign bus.mem_req_addr  = cur.addr;
   assign bus.mem_req_mask  = cur.mask;
   assign bus.mem_req_wdata = cur.data;
   assign bus.d_valid       = state == RESP;
   assign bus.d_opcode      = {2'b00, is_get};
   assign bus.d_param       = 2'b00;
   assign bus.d_size        = cur.size;
   assign bus.d_source      = cur.source;
   assign bus.d_sink        = 2'b00;
   assign bus.d_denied      = cur.deny;
   assign bus.d_data        = is_get ? rdata : 64'd0;
endmodule
